// File: rtl/pifo_sched_pkg.sv
// Shared definitions for the PIFO scheduler: FSM encoding and drop counter constants.
package pifo_sched_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_READY  = 2'd2
    } state_e;

    localparam int                        DROP_CNT_WIDTH = 16;
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX   = '1;

    // Saturating increment for the overflow drop counter.
    function automatic logic [DROP_CNT_WIDTH-1:0] drop_cnt_inc(
        input logic [DROP_CNT_WIDTH-1:0] cnt
    );
        return (cnt == DROP_CNT_MAX) ? cnt : cnt + 16'd1;
    endfunction

endpackage

// File: rtl/pifo_reg.sv
// PIFO storage: unsorted register file with valid bits, combinational min/max
// search, and a registered head that is invalidated whenever the contents change.
module pifo_reg #(
    parameter int L2_REG_WIDTH = 2,
    parameter int RANK_WIDTH   = 8,
    parameter int META_WIDTH   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ins_i,
    input  logic                  rem_i,
    input  logic                  rep_i,
    input  logic [RANK_WIDTH-1:0] rank_i,
    input  logic [META_WIDTH-1:0] meta_i,
    output logic                  head_vld_o,
    output logic [RANK_WIDTH-1:0] head_rank_o,
    output logic [META_WIDTH-1:0] head_meta_o
);

    localparam int DEPTH = 2**L2_REG_WIDTH;

    logic [DEPTH-1:0]                 vld_q, vld_d;
    logic [DEPTH-1:0][RANK_WIDTH-1:0] rank_q, rank_d;
    logic [DEPTH-1:0][META_WIDTH-1:0] meta_q, meta_d;

    logic [L2_REG_WIDTH-1:0] min_idx, max_idx, free_idx;
    logic                    min_found, max_found, free_found;

    logic                  head_vld_q;
    logic [RANK_WIDTH-1:0] head_rank_q;
    logic [META_WIDTH-1:0] head_meta_q;

    // Locate min-rank, max-rank and first free slot; ties keep the lowest index.
    always_comb begin
        min_idx    = '0;
        max_idx    = '0;
        free_idx   = '0;
        min_found  = 1'b0;
        max_found  = 1'b0;
        free_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                if (!min_found || rank_q[i] < rank_q[min_idx]) begin
                    min_idx   = L2_REG_WIDTH'(i);
                    min_found = 1'b1;
                end
                if (!max_found || rank_q[i] > rank_q[max_idx]) begin
                    max_idx   = L2_REG_WIDTH'(i);
                    max_found = 1'b1;
                end
            end else if (!free_found) begin
                free_idx   = L2_REG_WIDTH'(i);
                free_found = 1'b1;
            end
        end
    end

    // Next contents: insert+remove reuses the outgoing min slot, replace-max only if
    // the newcomer ranks strictly better than the current worst.
    always_comb begin
        vld_d  = vld_q;
        rank_d = rank_q;
        meta_d = meta_q;
        if (ins_i && rem_i) begin
            rank_d[min_idx] = rank_i;
            meta_d[min_idx] = meta_i;
        end else if (ins_i) begin
            vld_d[free_idx]  = 1'b1;
            rank_d[free_idx] = rank_i;
            meta_d[free_idx] = meta_i;
        end else if (rem_i) begin
            vld_d[min_idx] = 1'b0;
        end else if (rep_i && max_found && rank_i < rank_q[max_idx]) begin
            rank_d[max_idx] = rank_i;
            meta_d[max_idx] = meta_i;
        end
    end

    // Valid bits and head register; the head only refreshes on a quiet cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q       <= '0;
            head_vld_q  <= 1'b0;
            head_rank_q <= '0;
            head_meta_q <= '0;
        end else begin
            vld_q <= vld_d;
            if (ins_i || rem_i || rep_i) begin
                head_vld_q <= 1'b0;
            end else begin
                head_vld_q  <= min_found;
                head_rank_q <= rank_q[min_idx];
                head_meta_q <= meta_q[min_idx];
            end
        end
    end

    // Payload storage; qualified by vld_q so it needs no reset.
    always_ff @(posedge clk_i) begin
        rank_q <= rank_d;
        meta_q <= meta_d;
    end

    assign head_vld_o  = head_vld_q;
    assign head_rank_o = head_rank_q;
    assign head_meta_o = head_meta_q;

endmodule

// File: rtl/pifo_sched.sv
// PIFO scheduler: enqueue/dequeue handshakes, settle FSM, occupancy, burst guard.
// Optional feature macro PIFO_SCHED_DROP_EN: accept when full and replace/discard
// against the max-rank entry, counting each such event in drop_cnt_o.
module pifo_sched
    import pifo_sched_pkg::*;
#(
    parameter int L2_REG_WIDTH = 2,
    parameter int RANK_WIDTH   = 8,
    parameter int META_WIDTH   = 8,
    parameter int ENQ_BURST    = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enq_valid_i,
    output logic                      enq_ready_o,
    input  logic [RANK_WIDTH-1:0]     enq_rank_i,
    input  logic [META_WIDTH-1:0]     enq_meta_i,
    output logic                      deq_valid_o,
    input  logic                      deq_ready_i,
    output logic [RANK_WIDTH-1:0]     deq_rank_o,
    output logic [META_WIDTH-1:0]     deq_meta_o,
    output logic [L2_REG_WIDTH:0]     occupancy_o,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

    localparam int DEPTH = 2**L2_REG_WIDTH;
    localparam int BW    = $clog2(ENQ_BURST + 1);

    state_e                state_q, state_d;
    logic [L2_REG_WIDTH:0] occ_q, occ_d;
    logic [BW-1:0]         burst_q, burst_d;

    logic head_vld, head_out_vld;
    logic full, guard, space_ok;
    logic enq_fire, deq_fire, ins, rem, rep;

    assign full = (occ_q == (L2_REG_WIDTH+1)'(DEPTH));

    // The head is only offered once the register has had a quiet cycle to settle.
    always_comb begin
        state_d      = state_q;
        head_out_vld = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (enq_fire) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (enq_fire || deq_fire) state_d = ST_SETTLE;
                else if (occ_q == '0)     state_d = ST_EMPTY;
                else                      state_d = ST_READY;
            end
            ST_READY: begin
                head_out_vld = head_vld;
                if (enq_fire || deq_fire) state_d = ST_SETTLE;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    assign deq_valid_o = !rst_i && head_out_vld;
    assign deq_fire    = deq_valid_o && deq_ready_i;

    // Starvation guard: after a full burst, one quiet cycle lets the head settle.
    assign guard = (burst_q == BW'(ENQ_BURST)) && (occ_q != '0) && deq_ready_i;

`ifdef PIFO_SCHED_DROP_EN
    assign space_ok = 1'b1;
`else
    assign space_ok = !full || deq_fire;
`endif

    assign enq_ready_o = !rst_i && !guard && space_ok;
    assign enq_fire    = enq_valid_i && enq_ready_o;

    // A full-register enqueue without a paired dequeue becomes a replace-or-discard.
    assign rem = deq_fire;
    assign rep = enq_fire && full && !deq_fire;
    assign ins = enq_fire && !rep;

    // Occupancy follows the net insert/remove of this cycle.
    always_comb begin
        occ_d = occ_q;
        if (ins && !rem)      occ_d = occ_q + 1'b1;
        else if (rem && !ins) occ_d = occ_q - 1'b1;
    end

    // Burst counter saturates at ENQ_BURST and clears on any cycle without an enqueue.
    always_comb begin
        burst_d = burst_q;
        if (!enq_fire)                       burst_d = '0;
        else if (burst_q != BW'(ENQ_BURST))  burst_d = burst_q + 1'b1;
    end

    // Control state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            occ_q   <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            burst_q <= burst_d;
        end
    end

`ifdef PIFO_SCHED_DROP_EN
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;

    // Every full-register enqueue counts, whether it evicted the max or was discarded.
    always_ff @(posedge clk_i) begin
        if (rst_i)    drop_cnt_q <= '0;
        else if (rep) drop_cnt_q <= drop_cnt_inc(drop_cnt_q);
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    assign drop_cnt_o = '0;
`endif

    pifo_reg #(
        .L2_REG_WIDTH (L2_REG_WIDTH),
        .RANK_WIDTH   (RANK_WIDTH),
        .META_WIDTH   (META_WIDTH)
    ) u_reg (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ins_i       (ins),
        .rem_i       (rem),
        .rep_i       (rep),
        .rank_i      (enq_rank_i),
        .meta_i      (enq_meta_i),
        .head_vld_o  (head_vld),
        .head_rank_o (deq_rank_o),
        .head_meta_o (deq_meta_o)
    );

    assign occupancy_o = occ_q;

endmodule

// File: doc/pifo_sched.md
PIFO_SCHED -- requirements
Module: pifo_sched

Interface
REQ-001 The block SHALL have parameter L2_REG_WIDTH, default 2, meaning log2 of the PIFO register depth (DEPTH = 2**L2_REG_WIDTH).
REQ-002 The block SHALL have parameter RANK_WIDTH, default 8, meaning the rank field width.
REQ-003 The block SHALL have parameter META_WIDTH, default 8, meaning the metadata field width.
REQ-004 The block SHALL have parameter ENQ_BURST, default 4, meaning the maximum number of back-to-back enqueues before one forced quiet cycle.
REQ-005 clk  in  1  single clock; all logic is on the rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 enq_valid / enq_ready  in / out  1 / 1  enqueue handshake; a transfer occurs when both are high on a rising edge.
REQ-008 enq_rank / enq_meta  in  RANK_WIDTH / META_WIDTH  enqueued element.
REQ-009 deq_valid / deq_ready  out / in  1 / 1  dequeue handshake; a transfer occurs when both are high on a rising edge.
REQ-010 deq_rank / deq_meta  out  RANK_WIDTH / META_WIDTH  current minimum-rank element.
REQ-011 occupancy  out  L2_REG_WIDTH+1  number of stored entries.
REQ-012 drop_cnt  out  16  count of overflow drops, saturating at 0xFFFF.

Function
REQ-013 The FSM SHALL have three states: EMPTY (no entries), SETTLE (an insert or remove was issued last cycle, or the head is not yet valid), and READY (head output valid).
REQ-014 Any accepted enqueue or dequeue SHALL move the FSM to SETTLE.
- From SETTLE, the FSM SHALL move to READY after one cycle with no operation, or to EMPTY if occupancy is 0.
REQ-015 deq_valid SHALL be high only in READY and only while the internal head-valid flag is high; deq_rank and deq_meta SHALL be stable while deq_valid is high and deq_ready is low.
REQ-016 Each accepted dequeue SHALL issue exactly one remove; each accepted enqueue SHALL issue exactly one insert, in the same cycle as the handshake.
REQ-017 When READY and both handshakes fire, the block SHALL issue a simultaneous insert and remove; occupancy SHALL be unchanged.
REQ-018 When occupancy == DEPTH without the drop feature, enq_ready SHALL be low, except in READY with deq_ready high (the simultaneous-replace case).
REQ-019 After ENQ_BURST consecutive accepted enqueues, with occupancy > 0 and deq_ready high throughout, enq_ready SHALL be forced low for exactly one cycle so the head can settle (starvation guard); the burst counter SHALL clear on any cycle without an enqueue.
REQ-020 When occupancy == 0, deq_valid SHALL be low; a dequeue SHALL never be issued to an empty register.
REQ-021 occupancy SHALL track the register entry count exactly, including DEPTH.

Reset
REQ-022 While rst is high, the block SHALL drive: state=EMPTY, enq_ready=0, deq_valid=0, occupancy=0, drop_cnt=0, burst counter=0.
- All stored entries SHALL be invalidated.
REQ-023 On the first cycle after reset, enq_ready SHALL be 1.
REQ-024 Reset asserted mid-operation SHALL discard the in-flight insert or remove; no handshake completes in a reset cycle.

Configuration
REQ-025 Macro PIFO_SCHED_DROP_EN defined: when full, enq_ready SHALL stay high; an enqueue SHALL replace the max-rank entry if enq_rank < max rank, otherwise the incoming element is discarded.
- Either outcome SHALL increment drop_cnt by 1.
REQ-026 Macro PIFO_SCHED_DROP_EN undefined: REQ-018 backpressure SHALL apply, and drop_cnt SHALL be tied to 0.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (EMPTY/SETTLE/READY), the DROP_CNT_WIDTH=16 constant, and the drop-counter saturation value.
REQ-028 The block SHALL instantiate exactly one sub-module, pifo_reg, as the storage and min/max datapath.
- All sequencing and handshaking SHALL live in pifo_sched.

Verification
REQ-029 Reset, then enqueue ranks 5,3,7 on consecutive cycles, then deq_ready=1 -> deq_valid rises 2 cycles after the last enqueue; outputs in order 3,5,7 with matching meta; occupancy ends at 0 and the FSM returns to EMPTY.
REQ-030 Fill DEPTH=4 with ranks 10,20,30,40 (no macro), then enqueue 1 with deq_ready=0 -> enq_ready stays low and occupancy stays 4; raise deq_ready -> 10 dequeues while 1 inserts in the same cycle, and occupancy stays 4.
REQ-031 With PIFO_SCHED_DROP_EN, full with ranks 10,20,30,40, enqueue 15 then 50 -> 40 evicted, 50 discarded, drop_cnt=2; dequeue order 10,15,20,30.
REQ-032 enq_valid held high for 10 cycles with deq_ready=1 and ENQ_BURST=4 -> enq_ready low on cycle 5 and again after each further 4 accepts; at least one dequeue completes during the burst.
REQ-033 Assert rst for 1 cycle during a simultaneous insert/remove -> the next cycle shows occupancy=0, deq_valid=0, drop_cnt=0, enq_ready=1.
